// File: rtl/timing_acq_ctrl.sv
// ---------------------------------------------------------------------------
// timing_acq_ctrl
// Acquisition/tracking sequencer for the Gardner symbol-timing loop.
// It watches the per-symbol TED error and does the following:
//   - selects the loop-filter gain shifts for acquisition or tracking;
//   - freezes the loop while the matched filter fills up;
//   - pulses an integrator clear on start-up and on each acquisition retry;
//   - declares timing lock, and falls back to acquisition when lock is lost.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   enable       level; low forces IDLE
//   sym_strobe   one pulse per recovered symbol
//   ted_error    signed Gardner error, valid with sym_strobe
//   kp_shift     proportional gain shift to the loop filter
//   ki_shift     integral gain shift to the loop filter
//   loop_freeze  1 = loop filter holds nco_adj and integrator
//   int_clear    one-cycle pulse: loop filter zeroes its integrator
//   timing_lock  1 while in TRACK
//   state_o      00 IDLE, 01 HOLDOFF, 10 ACQUIRE, 11 TRACK
//   err_avg      unsigned leaky average of |ted_error| (diagnostic)
// ---------------------------------------------------------------------------
module timing_acq_ctrl #(
  parameter int DATA_WIDTH   = 12,
  parameter int HOLDOFF_SYMS = 16,
  parameter int AVG_SHIFT    = 4,
  parameter int LOCK_THR     = 40,
  parameter int UNLOCK_THR   = 120,
  parameter int LOCK_CNT     = 64,
  parameter int UNLOCK_CNT   = 32,
  parameter int ACQ_TIMEOUT  = 4096,
  parameter int KP_ACQ       = 6,
  parameter int KI_ACQ       = 12,
  parameter int KP_TRK       = 8,
  parameter int KI_TRK       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  sym_strobe,
  input  logic [DATA_WIDTH-1:0] ted_error,
  output logic [4:0]            kp_shift,
  output logic [4:0]            ki_shift,
  output logic                  loop_freeze,
  output logic                  int_clear,
  output logic                  timing_lock,
  output logic [1:0]            state_o,
  output logic [DATA_WIDTH-1:0] err_avg
);

  localparam int ACC_W  = DATA_WIDTH + AVG_SHIFT;
  localparam int HOLD_W = $clog2(HOLDOFF_SYMS + 1);
  localparam int LOCK_W = $clog2(LOCK_CNT + 1);
  localparam int UNLK_W = $clog2(UNLOCK_CNT + 1);
  localparam int TMR_W  = $clog2(ACQ_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    HOLDOFF = 2'b01,
    ACQUIRE = 2'b10,
    TRACK   = 2'b11
  } state_t;

  state_t              state;
  logic [ACC_W-1:0]    acc;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [LOCK_W-1:0]   lock_cnt;
  logic [UNLK_W-1:0]   unlock_cnt;
  logic [TMR_W-1:0]    acq_timer;

  logic [DATA_WIDTH-1:0] abs_e;
  logic [DATA_WIDTH-1:0] neg_e;
  logic [ACC_W-1:0]      acc_upd;
  logic [HOLD_W-1:0]     hold_nx;
  logic [LOCK_W-1:0]     lock_nx;
  logic [UNLK_W-1:0]     unlock_nx;
  logic [TMR_W-1:0]      tmr_nx;
  logic                  hold_done;
  logic                  lock_hit;
  logic                  unlock_hit;
  logic                  timeout_hit;

  // The average is the upper slice of the accumulator, so it is a registered
  // value and always reflects the state before the current strobe is applied.
  assign err_avg = acc[ACC_W-1:AVG_SHIFT];
  assign state_o = state;

  // Saturating magnitude of the TED error: the most negative code has no
  // positive twin, so it is clamped to the largest positive value.
  always_comb begin
    neg_e = ~ted_error + 1'b1;
    abs_e = ted_error;
    if (ted_error[DATA_WIDTH-1]) begin
      if (ted_error == {1'b1, {(DATA_WIDTH-1){1'b0}}})
        abs_e = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else
        abs_e = neg_e;
    end
  end

  // Next values of the leaky average and the saturating counters, and the
  // qualification decisions built from the pre-update average. The leaky
  // accumulator settles at or below (2^DATA_WIDTH-1 max input)*2^AVG_SHIFT+
  // 2^AVG_SHIFT-1, so ACC_W bits hold it without overflow.
  always_comb begin
    acc_upd   = acc + ACC_W'(abs_e) - (acc >> AVG_SHIFT);

    hold_nx   = (hold_cnt == HOLD_W'(HOLDOFF_SYMS)) ? hold_cnt : hold_cnt + 1'b1;
    hold_done = (hold_nx == HOLD_W'(HOLDOFF_SYMS));

    lock_nx   = '0;
    if (err_avg < DATA_WIDTH'(LOCK_THR))
      lock_nx = (lock_cnt == LOCK_W'(LOCK_CNT)) ? lock_cnt : lock_cnt + 1'b1;
    lock_hit  = (lock_nx == LOCK_W'(LOCK_CNT));

    unlock_nx = '0;
    if (err_avg > DATA_WIDTH'(UNLOCK_THR))
      unlock_nx = (unlock_cnt == UNLK_W'(UNLOCK_CNT)) ? unlock_cnt : unlock_cnt + 1'b1;
    unlock_hit = (unlock_nx == UNLK_W'(UNLOCK_CNT));

    tmr_nx      = (acq_timer == TMR_W'(ACQ_TIMEOUT)) ? acq_timer : acq_timer + 1'b1;
    timeout_hit = (tmr_nx == TMR_W'(ACQ_TIMEOUT));
  end

  // Sequencer: state, counters, accumulator and every output are updated
  // here. Dropping enable beats any strobe on the same cycle. In ACQUIRE a
  // lock decision beats a coincident timeout, so there is no clear on lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      kp_shift    <= 5'(KP_ACQ);
      ki_shift    <= 5'(KI_ACQ);
      loop_freeze <= 1'b1;
      int_clear   <= 1'b0;
      timing_lock <= 1'b0;
      acc         <= '0;
      hold_cnt    <= '0;
      lock_cnt    <= '0;
      unlock_cnt  <= '0;
      acq_timer   <= '0;
    end else if (!enable) begin
      state       <= IDLE;
      kp_shift    <= 5'(KP_ACQ);
      ki_shift    <= 5'(KI_ACQ);
      loop_freeze <= 1'b1;
      int_clear   <= 1'b0;
      timing_lock <= 1'b0;
      acc         <= '0;
      hold_cnt    <= '0;
      lock_cnt    <= '0;
      unlock_cnt  <= '0;
      acq_timer   <= '0;
    end else begin
      int_clear <= 1'b0;
      case (state)
        IDLE: begin
          state       <= HOLDOFF;
          int_clear   <= 1'b1;
          loop_freeze <= 1'b1;
          acc         <= '0;
          hold_cnt    <= '0;
          lock_cnt    <= '0;
          unlock_cnt  <= '0;
          acq_timer   <= '0;
        end

        HOLDOFF: begin
          if (sym_strobe) begin
            acc      <= acc_upd;
            hold_cnt <= hold_nx;
            if (hold_done) begin
              state       <= ACQUIRE;
              loop_freeze <= 1'b0;
              lock_cnt    <= '0;
              acq_timer   <= '0;
            end
          end
        end

        ACQUIRE: begin
          if (sym_strobe) begin
            if (lock_hit) begin
              state       <= TRACK;
              kp_shift    <= 5'(KP_TRK);
              ki_shift    <= 5'(KI_TRK);
              timing_lock <= 1'b1;
              acc         <= acc_upd;
              lock_cnt    <= lock_nx;
              acq_timer   <= tmr_nx;
              unlock_cnt  <= '0;
            end else if (timeout_hit) begin
              int_clear <= 1'b1;
              acc       <= '0;
              lock_cnt  <= '0;
              acq_timer <= '0;
            end else begin
              acc       <= acc_upd;
              lock_cnt  <= lock_nx;
              acq_timer <= tmr_nx;
            end
          end
        end

        TRACK: begin
          if (sym_strobe) begin
            acc <= acc_upd;
            if (unlock_hit) begin
              state       <= ACQUIRE;
              kp_shift    <= 5'(KP_ACQ);
              ki_shift    <= 5'(KI_ACQ);
              timing_lock <= 1'b0;
              lock_cnt    <= '0;
              acq_timer   <= '0;
              unlock_cnt  <= '0;
            end else begin
              unlock_cnt <= unlock_nx;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timing_acq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timing_acq_ctrl
// Directed bench for timing_acq_ctrl. The stimulus process pushes the
// expected output events onto a queue before it drives the strobes that
// cause them. A monitor treats every state change and every int_clear cycle
// as an event, pops the queue and compares it. The comparison covers the
// outputs and the strobe index at which the event appeared. Averages and
// static output values are checked directly at chosen points.
// ---------------------------------------------------------------------------
module tb_timing_acq_ctrl;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        sym_strobe;
  logic [11:0] ted_error;
  logic [4:0]  kp_shift;
  logic [4:0]  ki_shift;
  logic        loop_freeze;
  logic        int_clear;
  logic        timing_lock;
  logic [1:0]  state_o;
  logic [11:0] err_avg;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_HOLD = 2'b01;
  localparam logic [1:0] S_ACQ  = 2'b10;
  localparam logic [1:0] S_TRK  = 2'b11;

  typedef struct packed {
    logic [1:0] st;
    logic [4:0] kp;
    logic [4:0] ki;
    logic       frz;
    logic       lck;
    logic       ic;
    int         idx;
  } event_t;

  event_t expq[$];
  int     checks;
  int     errors;
  int     strobe_count;
  logic   mon_en;
  logic [1:0] prev_state;

  timing_acq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .sym_strobe  (sym_strobe),
    .ted_error   (ted_error),
    .kp_shift    (kp_shift),
    .ki_shift    (ki_shift),
    .loop_freeze (loop_freeze),
    .int_clear   (int_clear),
    .timing_lock (timing_lock),
    .state_o     (state_o),
    .err_avg     (err_avg)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: on the falling edge, any state change or int_clear cycle is an
  // event. It must match the head of the expected queue, and a surplus
  // event is an error. A clear pulse longer than one cycle yields a surplus
  // event.
  always @(negedge clk) begin
    if (mon_en && ((state_o != prev_state) || int_clear)) begin
      checks = checks + 1;
      if (expq.size() == 0) begin
        errors = errors + 1;
        $display("[TB] FAIL unexpected_event: got st=%0d ic=%0b idx=%0d, required none",
                 state_o, int_clear, strobe_count);
      end else begin
        event_t e;
        e = expq.pop_front();
        if (state_o !== e.st || kp_shift !== e.kp || ki_shift !== e.ki ||
            loop_freeze !== e.frz || timing_lock !== e.lck ||
            int_clear !== e.ic || strobe_count != e.idx) begin
          errors = errors + 1;
          $display("[TB] FAIL event: got st=%0d kp=%0d ki=%0d frz=%0b lck=%0b ic=%0b idx=%0d, required st=%0d kp=%0d ki=%0d frz=%0b lck=%0b ic=%0b idx=%0d",
                   state_o, kp_shift, ki_shift, loop_freeze, timing_lock, int_clear,
                   strobe_count, e.st, e.kp, e.ki, e.frz, e.lck, e.ic, e.idx);
        end
      end
    end
    prev_state = state_o;
  end

  // Queues one expected event.
  task automatic expectEvent(input logic [1:0] st, input logic ic, input int idx);
    event_t e;
    e.st  = st;
    e.kp  = (st == S_TRK) ? 5'd8 : 5'd6;
    e.ki  = (st == S_TRK) ? 5'd16 : 5'd12;
    e.frz = (st == S_IDLE || st == S_HOLD);
    e.lck = (st == S_TRK);
    e.ic  = ic;
    e.idx = idx;
    expq.push_back(e);
  endtask

  // One symbol: strobe high for one clock, then three idle clocks. The
  // enable level is applied on the same edge as the strobe.
  task automatic applyStimulus(input logic [11:0] err, input logic en);
    @(posedge clk);
    #1;
    sym_strobe   = 1'b1;
    ted_error    = err;
    enable       = en;
    strobe_count = strobe_count + 1;
    @(posedge clk);
    #1;
    sym_strobe = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Direct check of all outputs at the next falling edge.
  task automatic checkOutput(input string name, input logic [1:0] st,
                             input logic frz, input logic ic, input logic [11:0] avg);
    logic [4:0] ekp;
    logic [4:0] eki;
    logic       elk;
    ekp = (st == S_TRK) ? 5'd8 : 5'd6;
    eki = (st == S_TRK) ? 5'd16 : 5'd12;
    elk = (st == S_TRK);
    @(negedge clk);
    checks = checks + 1;
    if (state_o !== st || kp_shift !== ekp || ki_shift !== eki ||
        loop_freeze !== frz || timing_lock !== elk || int_clear !== ic ||
        err_avg !== avg) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got st=%0d kp=%0d ki=%0d frz=%0b lck=%0b ic=%0b avg=%0d, required st=%0d kp=%0d ki=%0d frz=%0b lck=%0b ic=%0b avg=%0d",
               name, state_o, kp_shift, ki_shift, loop_freeze, timing_lock, int_clear,
               err_avg, st, ekp, eki, frz, elk, ic, avg);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    strobe_count = 0;
    mon_en       = 1'b0;
    prev_state   = S_IDLE;
    rst          = 1'b1;
    enable       = 1'b0;
    sym_strobe   = 1'b0;
    ted_error    = 12'd0;

    // Test 1: reset values, then enable with no strobes.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_values", S_IDLE, 1'b1, 1'b0, 12'd0);
    mon_en = 1'b1;
    expectEvent(S_HOLD, 1'b1, strobe_count);
    @(posedge clk);
    #1;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    checkOutput("holdoff_idle", S_HOLD, 1'b1, 1'b0, 12'd0);

    // Test 2: 16 zero-error strobes to ACQUIRE, then 64 more to TRACK.
    expectEvent(S_ACQ, 1'b0, strobe_count + 16);
    expectEvent(S_TRK, 1'b0, strobe_count + 80);
    for (int i = 0; i < 80; i++) applyStimulus(12'd0, 1'b1);
    checkOutput("track_reached", S_TRK, 1'b0, 1'b0, 12'd0);

    // Test 3: constant +600 in TRACK. The pre-update average first exceeds
    // 120 on strobe 5 (136), so strobes 5..36 qualify and lock drops on 36.
    expectEvent(S_ACQ, 1'b0, strobe_count + 36);
    for (int i = 0; i < 4; i++) applyStimulus(12'd600, 1'b1);
    checkOutput("avg_after_4x600", S_TRK, 1'b0, 1'b0, 12'd136);
    for (int i = 0; i < 32; i++) applyStimulus(12'd600, 1'b1);

    // Test 4: alternating +/-500 keeps the average above 40, so the timer
    // expires on ACQUIRE strobe 4096 with a single clear pulse.
    expectEvent(S_ACQ, 1'b1, strobe_count + 4096);
    for (int i = 0; i < 4096; i++)
      applyStimulus((i % 2 == 0) ? 12'd500 : 12'hE0C, 1'b1);
    checkOutput("after_timeout", S_ACQ, 1'b0, 1'b0, 12'd0);

    // Test 5: most negative error every strobe; the average saturates at 2047.
    for (int i = 0; i < 300; i++) applyStimulus(12'h800, 1'b1);
    checkOutput("avg_saturated", S_ACQ, 1'b0, 1'b0, 12'd2047);

    // Test 6a: reset in mid-ACQUIRE restores every reset value.
    expectEvent(S_IDLE, 1'b0, strobe_count);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_mid_acq", S_IDLE, 1'b1, 1'b0, 12'd0);

    // Strobes while disabled must not move anything.
    for (int i = 0; i < 2; i++) applyStimulus(12'd700, 1'b0);
    checkOutput("idle_ignores_strobe", S_IDLE, 1'b1, 1'b0, 12'd0);

    // Test 6b: back to TRACK, then drop enable together with a strobe.
    expectEvent(S_HOLD, 1'b1, strobe_count);
    expectEvent(S_ACQ,  1'b0, strobe_count + 16);
    expectEvent(S_TRK,  1'b0, strobe_count + 80);
    expectEvent(S_IDLE, 1'b0, strobe_count + 81);
    @(posedge clk);
    #1;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 80; i++) applyStimulus(12'd0, 1'b1);
    checkOutput("track_again", S_TRK, 1'b0, 1'b0, 12'd0);
    applyStimulus(12'd0, 1'b0);
    checkOutput("disable_in_track", S_IDLE, 1'b1, 1'b0, 12'd0);

    // Every queued event must have been seen.
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks = checks + 1;
    if (expq.size() != 0) begin
      errors = errors + 1;
      $display("[TB] FAIL events_pending: got %0d left, required 0", expq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
